axi4l_reg_slave: RTL
====================

// Module: axi4l_reg_slave
// PURPOSE
//  AXI4-Lite responder (slave end of IF_AXI4L): a bank of 32-bit memory-mapped control/status registers.
//  Low indices are RW control registers driven out to fabric; high indices are RO status registers sampled from fabric.
//  Sits behind any AXI4-Lite master / interconnect port.
// PARAMETERS
//  N_REGS   16  total registers; word index = addr[IDX_W+1:2], IDX_W = $clog2(N_REGS) (localparam)
//  N_RW      8  indices 0..N_RW-1 are RW; N_RW..N_REGS-1 are RO; 1 <= N_RW < N_REGS
// PORTS
//  ACLK          in   1                  clock, all logic rising-edge
//  ARESET        in   1                  reset, synchronous, active-high
//  AWADDR        in   32                 write address;  AWPROT in 3 (ignored); AWVALID in 1; AWREADY out 1
//  WDATA         in   32                 write data;     WSTRB in 4;  WVALID in 1;  WREADY out 1
//  BRESP         out  2                  write response; BVALID out 1; BREADY in 1
//  ARADDR        in   32                 read address;   ARPROT in 3 (ignored); ARVALID in 1; ARREADY out 1
//  RDATA         out  32                 read data;      RRESP out 2;  RVALID out 1;  RREADY in 1
//  reg_q         out  N_RW*32            RW register contents, reg k at [k*32+:32]
//  reg_wr_pulse  out  N_RW               1-cycle pulse, register k was written
//  ro_in         in   (N_REGS-N_RW)*32   RO status values, RO index j=k-N_RW at [j*32+:32]
// BEHAVIOUR
//  Reset (ARESET=1, sampled at edge): AW/W holds empty, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0,
//   reg_q=0, reg_wr_pulse=0. All READY outputs forced 0 while ARESET=1. Reset mid-transaction abandons it;
//   no B/R response is issued for it.
//  Write path: AW and W accepted independently, each into a 1-entry hold. AWREADY=!aw_full, WREADY=!w_full.
//   Either may arrive first or both in the same cycle; a full hold stalls its channel only.
//  Commit: first cycle with aw_full & w_full & !BVALID. In commit cycle: decode, update, clear both holds.
//   Next cycle: BVALID=1, BRESP set, reg_wr_pulse[k]=1 (RW hit with WSTRB!=0). BVALID held with
//   stable BRESP until BREADY; cleared the cycle after the B handshake.
//   AW+W together at cycle 0 -> commit cycle 1 -> BVALID cycle 2.
//  Write decode: addr[1:0] ignored. Index < N_RW: byte lane b updated iff WSTRB[b]; BRESP=OKAY (WSTRB=0: OKAY, no change, no pulse).
//   N_RW <= index < N_REGS: no effect, BRESP=OKAY. addr >= N_REGS*4 (any upper bit set): no effect, BRESP=SLVERR.
//  Read path: one outstanding read. ARREADY=!RVALID. AR handshake at cycle 0 -> RVALID,RDATA,RRESP at cycle 1,
//   held stable until RREADY; ARREADY returns the cycle after the R handshake.
//   RW index -> reg_q value; RO index -> ro_in sampled in the AR handshake cycle; out of range -> RDATA=0, SLVERR.
//  Simultaneous read of reg k and write commit to reg k in the same cycle: read returns the pre-write value.
//  Read and write paths fully independent; BREADY/RREADY low indefinitely must stall without data loss.
//  RRESP/BRESP only ever OKAY(2'b00) or SLVERR(2'b10).
// STRUCTURE
//  Package axi4l_pkg: resp_t enum {OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11},
//   AXI4L_DATA_W=32, AXI4L_STRB_W=4, function strb_merge(old, new, strb).
//  Sub-module axi4l_hold_slot (parameter W): 1-entry valid/data register with ready=!full, load, clear;
//   instantiated for AW (32b) and W (36b: data+strb).
// TESTING
//  1 AW+W same cycle, addr 0x04, data 0xDEADBEEF, strb 0xF -> BVALID cycle 2, OKAY; reg_q[63:32]=0xDEADBEEF; pulse[1]=1 one cycle.
//  2 W first then AW 3 cycles later, addr 0x00, data 0x11223344, strb 0x5 over 0xFFFFFFFF -> reg0=0xFF22FF44, OKAY.
//  3 Write addr 0x40 (N_REGS=16) -> SLVERR, no reg/pulse change; read 0x40 -> RDATA=0, SLVERR.
//  4 ro_in index 8 = 0xA5A5A5A5, read 0x20 -> RDATA=0xA5A5A5A5, OKAY one cycle after AR; write 0x20 -> OKAY, value unchanged.
//  5 BREADY=0 for 10 cycles after a write, second AW/W offered -> both held (then stalled), BVALID/BRESP stable,
//    second commit only after B handshake; same with RREADY=0 -> ARREADY stays 0, RDATA stable.
//  6 ARESET asserted with aw_full=1, BVALID=1 -> next cycle all VALID=0, reg_q=0; a fresh write then completes normally.

Source files
------------

// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite types and helpers for the register slave.
package axi4l_pkg;

   localparam int AXI4L_DATA_W = 32;
   localparam int AXI4L_STRB_W = 4;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   function automatic logic [AXI4L_DATA_W-1:0] strb_merge(
      input logic [AXI4L_DATA_W-1:0] old_v,
      input logic [AXI4L_DATA_W-1:0] new_v,
      input logic [AXI4L_STRB_W-1:0] strb
   );
      logic [AXI4L_DATA_W-1:0] r_v;
      for (int b = 0; b < AXI4L_STRB_W; b++) begin
         r_v[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
      end
      return r_v;
   endfunction

endpackage

// File: rtl/axi4l_hold_slot.sv
// One-entry holding register: accepts a beat when empty, keeps it until cleared.
module axi4l_hold_slot #(
   parameter int W = 32
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_valid,
   input  logic [W-1:0] i_data,
   input  logic         i_clear,
   output logic         o_ready,
   output logic         o_full,
   output logic [W-1:0] o_data
);

   logic         r_full;
   logic [W-1:0] r_data;
   logic         w_load;

   // Ready is withheld during reset so nothing is accepted into a slot being flushed.
   assign o_ready = !r_full && !i_rst;
   assign w_load  = i_valid && o_ready;
   assign o_full  = r_full;
   assign o_data  = r_data;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_full <= 1'b0;
         r_data <= '0;
      end else begin
         if (i_clear) begin
            r_full <= 1'b0;
         end else if (w_load) begin
            r_full <= 1'b1;
         end
         if (w_load) begin
            r_data <= i_data;
         end
      end
   end

endmodule

// File: rtl/axi4l_reg_slave.sv
// AXI4-Lite register bank: low indices are RW control registers, high indices are RO status inputs.
module axi4l_reg_slave
   import axi4l_pkg::*;
#(
   parameter int N_REGS = 16,
   parameter int N_RW   = 8
) (
   input  logic                         ACLK,
   input  logic                         ARESET,
   input  logic [31:0]                  AWADDR,
   input  logic [2:0]                   AWPROT,
   input  logic                         AWVALID,
   output logic                         AWREADY,
   input  logic [31:0]                  WDATA,
   input  logic [3:0]                   WSTRB,
   input  logic                         WVALID,
   output logic                         WREADY,
   output logic [1:0]                   BRESP,
   output logic                         BVALID,
   input  logic                         BREADY,
   input  logic [31:0]                  ARADDR,
   input  logic [2:0]                   ARPROT,
   input  logic                         ARVALID,
   output logic                         ARREADY,
   output logic [31:0]                  RDATA,
   output logic [1:0]                   RRESP,
   output logic                         RVALID,
   input  logic                         RREADY,
   output logic [N_RW*32-1:0]           reg_q,
   output logic [N_RW-1:0]              reg_wr_pulse,
   input  logic [(N_REGS-N_RW)*32-1:0]  ro_in
);

   localparam int IDX_W = $clog2(N_REGS);
   localparam int N_RO  = N_REGS - N_RW;

   logic [31:0]     w_aw_addr;
   logic [35:0]     w_wd;
   logic            w_aw_full;
   logic            w_w_full;
   logic            w_commit;
   logic            w_aw_oor;
   logic            w_aw_rw;
   logic [IDX_W-1:0] w_aw_idx;
   logic            w_ar_oor;
   logic [IDX_W-1:0] w_ar_idx;
   logic [31:0]     w_rd_data;
   logic            w_unused;

   logic [31:0]     r_regs [N_RW];
   logic [N_RW-1:0] r_pulse;
   logic            r_bvalid;
   resp_t           r_bresp;
   logic            r_rvalid;
   logic [31:0]     r_rdata;
   resp_t           r_rresp;

   assign w_unused = ^{AWPROT, ARPROT};

   axi4l_hold_slot #(.W(32)) u_aw_hold (
      .i_clk   (ACLK),
      .i_rst   (ARESET),
      .i_valid (AWVALID),
      .i_data  (AWADDR),
      .i_clear (w_commit),
      .o_ready (AWREADY),
      .o_full  (w_aw_full),
      .o_data  (w_aw_addr)
   );

   axi4l_hold_slot #(.W(36)) u_w_hold (
      .i_clk   (ACLK),
      .i_rst   (ARESET),
      .i_valid (WVALID),
      .i_data  ({WSTRB, WDATA}),
      .i_clear (w_commit),
      .o_ready (WREADY),
      .o_full  (w_w_full),
      .o_data  (w_wd)
   );

   // A new write commits only once the previous B response has been taken.
   assign w_commit = w_aw_full && w_w_full && !r_bvalid;
   assign w_aw_oor = (w_aw_addr >= 32'(N_REGS*4));
   assign w_aw_idx = w_aw_addr[IDX_W+1:2];
   assign w_aw_rw  = !w_aw_oor && (32'(w_aw_idx) < 32'(N_RW));

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         for (int k = 0; k < N_RW; k++) begin
            r_regs[k] <= '0;
         end
         r_pulse  <= '0;
         r_bvalid <= 1'b0;
         r_bresp  <= OKAY;
      end else begin
         r_pulse <= '0;
         if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_aw_oor ? SLVERR : OKAY;
            for (int k = 0; k < N_RW; k++) begin
               if (w_aw_rw && (w_aw_idx == IDX_W'(k))) begin
                  r_regs[k]  <= strb_merge(r_regs[k], w_wd[31:0], w_wd[35:32]);
                  r_pulse[k] <= |w_wd[35:32];
               end
            end
         end else if (r_bvalid && BREADY) begin
            r_bvalid <= 1'b0;
         end
      end
   end

   assign w_ar_oor = (ARADDR >= 32'(N_REGS*4));
   assign w_ar_idx = ARADDR[IDX_W+1:2];

   // Reads see r_regs before any same-cycle commit lands.
   always_comb begin
      w_rd_data = '0;
      if (!w_ar_oor) begin
         for (int k = 0; k < N_RW; k++) begin
            if (w_ar_idx == IDX_W'(k)) w_rd_data = r_regs[k];
         end
         for (int j = 0; j < N_RO; j++) begin
            if (w_ar_idx == IDX_W'(j + N_RW)) w_rd_data = ro_in[j*32 +: 32];
         end
      end
   end

   assign ARREADY = !r_rvalid && !ARESET;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_rresp  <= OKAY;
      end else if (ARVALID && ARREADY) begin
         r_rvalid <= 1'b1;
         r_rdata  <= w_rd_data;
         r_rresp  <= w_ar_oor ? SLVERR : OKAY;
      end else if (r_rvalid && RREADY) begin
         r_rvalid <= 1'b0;
      end
   end

   for (genvar g = 0; g < N_RW; g++) begin : g_regq
      assign reg_q[g*32 +: 32] = r_regs[g];
   end

   assign reg_wr_pulse = r_pulse;
   assign BVALID       = r_bvalid;
   assign BRESP        = r_bresp;
   assign RVALID       = r_rvalid;
   assign RDATA        = r_rdata;
   assign RRESP        = r_rresp;

endmodule
